// File: rtl/conv2d_stream_if.sv
// Stream interface for conv2d_stream.
// Carries the input column beat channel (i_valid/o_ready/i_mode/i_sof/i_col) and the
// output sample channel (o_valid/i_ready/o_data/o_sat), plus the o_kdone status level.
// slave  : the convolution engine's view.
// master : the view of whatever drives columns in and consumes samples out.
interface conv2d_stream_if #(
    parameter int unsigned K      = 3,
    parameter int unsigned DATA_W = 8,
    parameter int unsigned OUT_W  = 13
);
    logic                  i_valid;
    logic                  o_ready;
    logic                  i_mode;
    logic                  i_sof;
    logic [K*DATA_W-1:0]   i_col;
    logic                  o_valid;
    logic                  i_ready;
    logic [OUT_W-1:0]      o_data;
    logic                  o_sat;
    logic                  o_kdone;

    modport slave (
        input  i_valid, i_mode, i_sof, i_col, i_ready,
        output o_ready, o_valid, o_data, o_sat, o_kdone
    );

    modport master (
        output i_valid, i_mode, i_sof, i_col, i_ready,
        input  o_ready, o_valid, o_data, o_sat, o_kdone
    );
endinterface

// File: rtl/conv2d_stream.sv
// Pipelined KxK 2-D convolution engine.
// Loads a KxK signed kernel one column per beat (i_mode=0), then slides a K-column window
// over streamed image columns (i_mode=1). Every full window yields one multiply-accumulate
// result, arithmetically shifted right by SHIFT, saturated to OUT_W bits and emitted in
// offset-binary form.
// Ports:
//   clk, rst : clock, synchronous active-high reset
//   bus      : conv2d_stream_if slave (column beats in, samples out, o_kdone status)
// Pipeline: S1 registers the KxK products, S2 registers sum/shift/saturate. Both stages
// hold while the output sample is valid but not accepted.
module conv2d_stream #(
    parameter int unsigned K      = 3,
    parameter int unsigned DATA_W = 8,
    parameter int unsigned ACC_W  = 20,
    parameter int unsigned SHIFT  = 7,
    parameter int unsigned OUT_W  = 13
) (
    input logic            clk,
    input logic            rst,
    conv2d_stream_if.slave bus
);
    localparam int unsigned CntW  = $clog2(K + 1);
    localparam int unsigned ProdW = 2 * DATA_W;
    localparam logic signed [ACC_W-1:0] OutMax = ACC_W'((1 << (OUT_W - 1)) - 1);
    localparam logic signed [ACC_W-1:0] OutMin = ~OutMax;

    typedef logic signed [DATA_W-1:0] pix_t;
    typedef enum logic [0:0] {StNoKer, StReady} state_e;

    state_e                  state_q, state_d;
    logic [CntW-1:0]         kcnt_q, kcnt_d;
    logic [CntW-1:0]         fcnt_q, fcnt_d;
    pix_t                    kern_q [K][K];
    pix_t                    kern_d [K][K];
    pix_t                    win_q [K][K];
    pix_t                    win_d [K][K];
    pix_t                    col [K];
    logic signed [ProdW-1:0] prod_q [K][K];
    logic signed [ProdW-1:0] prod_d [K][K];
    logic                    s1_valid_q, s1_valid_d;
    logic                    s2_valid_q, s2_valid_d;
    logic [OUT_W-1:0]        data_q, data_d;
    logic                    sat_q, sat_d;
    logic                    stall, accept, issue, sat_n;
    logic signed [ACC_W-1:0] acc_sum, acc_shr;
    logic signed [OUT_W-1:0] clip;

    // Kernel store, window and fill tracking.
    always_comb begin
        stall   = s2_valid_q && !bus.i_ready;
        accept  = bus.i_valid && !stall;
        state_d = state_q;
        kcnt_d  = kcnt_q;
        fcnt_d  = fcnt_q;
        kern_d  = kern_q;
        win_d   = win_q;
        issue   = 1'b0;
        for (int unsigned r = 0; r < K; r++) begin
            col[r] = bus.i_col[r*DATA_W +: DATA_W];
        end
        if (accept && !bus.i_mode) begin
            if (kcnt_q == CntW'(K)) begin
                // Reload: restart the kernel and discard the partially filled window.
                kcnt_d    = CntW'(1);
                fcnt_d    = '0;
                kern_d[0] = col;
            end else begin
                for (int unsigned c = 0; c < K; c++) begin
                    if (CntW'(c) == kcnt_q) begin
                        kern_d[c] = col;
                    end
                end
                kcnt_d = kcnt_q + 1'b1;
            end
        end
        // Image beats without a full kernel are accepted and dropped.
        if (accept && bus.i_mode && state_q == StReady) begin
            for (int unsigned c = 0; c < K - 1; c++) begin
                win_d[c] = win_q[c + 1];
            end
            win_d[K-1] = col;
            if (bus.i_sof) begin
                fcnt_d = CntW'(1);
            end else if (fcnt_q != CntW'(K)) begin
                fcnt_d = fcnt_q + 1'b1;
            end
            issue = (fcnt_d == CntW'(K));
        end
        state_d = (kcnt_d == CntW'(K)) ? StReady : StNoKer;
    end

    // S2 combinational part: sum, floor shift, clamp.
    always_comb begin
        acc_sum = '0;
        for (int unsigned c = 0; c < K; c++) begin
            for (int unsigned r = 0; r < K; r++) begin
                acc_sum = acc_sum + {{(ACC_W - ProdW){prod_q[c][r][ProdW-1]}}, prod_q[c][r]};
            end
        end
        acc_shr = acc_sum >>> SHIFT;
        if (acc_shr > OutMax) begin
            clip  = OutMax[OUT_W-1:0];
            sat_n = 1'b1;
        end else if (acc_shr < OutMin) begin
            clip  = OutMin[OUT_W-1:0];
            sat_n = 1'b1;
        end else begin
            clip  = acc_shr[OUT_W-1:0];
            sat_n = 1'b0;
        end
    end

    // Pipeline next state. Products use the current kernel, so later reloads never
    // affect tokens already issued.
    always_comb begin
        s1_valid_d = s1_valid_q;
        s2_valid_d = s2_valid_q;
        prod_d     = prod_q;
        data_d     = data_q;
        sat_d      = sat_q;
        if (!stall) begin
            s1_valid_d = issue;
            s2_valid_d = s1_valid_q;
            if (issue) begin
                for (int unsigned c = 0; c < K; c++) begin
                    for (int unsigned r = 0; r < K; r++) begin
                        prod_d[c][r] = ProdW'(kern_q[c][r]) * ProdW'(win_d[c][r]);
                    end
                end
            end
            if (s1_valid_q) begin
                data_d = {~clip[OUT_W-1], clip[OUT_W-2:0]};
                sat_d  = sat_n;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StNoKer;
            kcnt_q     <= '0;
            fcnt_q     <= '0;
            s1_valid_q <= 1'b0;
            s2_valid_q <= 1'b0;
            data_q     <= '0;
            sat_q      <= 1'b0;
            for (int unsigned c = 0; c < K; c++) begin
                for (int unsigned r = 0; r < K; r++) begin
                    kern_q[c][r] <= '0;
                    win_q[c][r]  <= '0;
                    prod_q[c][r] <= '0;
                end
            end
        end else begin
            state_q    <= state_d;
            kcnt_q     <= kcnt_d;
            fcnt_q     <= fcnt_d;
            s1_valid_q <= s1_valid_d;
            s2_valid_q <= s2_valid_d;
            data_q     <= data_d;
            sat_q      <= sat_d;
            kern_q     <= kern_d;
            win_q      <= win_d;
            prod_q     <= prod_d;
        end
    end

    assign bus.o_ready = !stall;
    assign bus.o_valid = s2_valid_q;
    assign bus.o_data  = data_q;
    assign bus.o_sat   = sat_q;
    assign bus.o_kdone = (state_q == StReady);
endmodule

// File: tb/tb_conv2d_stream.sv
// Testbench for conv2d_stream. Two instances share all stimulus: dut0 with default
// parameters (SHIFT=7) and dut1 with SHIFT=0. A behavioural model computes each expected
// sample from the kernel/window contents with plain integer arithmetic; accepted output
// samples are recorded and compared per scenario.
module tb_conv2d_stream;
    localparam int K  = 3;
    localparam int DW = 8;
    localparam int OW = 13;
    localparam int CW = K * DW;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_mode = 1'b0;
    logic          in_sof = 1'b0;
    logic [CW-1:0] in_col = '0;
    logic          in_ready = 1'b1;
    logic          rnd_rdy = 1'b0;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    conv2d_stream_if #(.K(K), .DATA_W(DW), .OUT_W(OW)) bus0 ();
    conv2d_stream_if #(.K(K), .DATA_W(DW), .OUT_W(OW)) bus1 ();

    assign bus0.i_valid = in_valid;
    assign bus0.i_mode  = in_mode;
    assign bus0.i_sof   = in_sof;
    assign bus0.i_col   = in_col;
    assign bus0.i_ready = in_ready;
    assign bus1.i_valid = in_valid;
    assign bus1.i_mode  = in_mode;
    assign bus1.i_sof   = in_sof;
    assign bus1.i_col   = in_col;
    assign bus1.i_ready = in_ready;

    conv2d_stream #(.K(K), .DATA_W(DW), .ACC_W(20), .SHIFT(7), .OUT_W(OW)) dut0 (
        .clk (clk),
        .rst (rst),
        .bus (bus0)
    );

    conv2d_stream #(.K(K), .DATA_W(DW), .ACC_W(20), .SHIFT(0), .OUT_W(OW)) dut1 (
        .clk (clk),
        .rst (rst),
        .bus (bus1)
    );

    always #5 clk = ~clk;

    // Observed samples: {o_data, o_sat}, captured where the output handshake will happen.
    logic [OW:0] obs0[$];
    logic [OW:0] obs1[$];
    int          obs_cyc[$];
    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (!rst && bus0.o_valid && in_ready) begin
            obs0.push_back({bus0.o_data, bus0.o_sat});
            obs_cyc.push_back(cyc);
        end
        if (!rst && bus1.o_valid && in_ready) obs1.push_back({bus1.o_data, bus1.o_sat});
    end

    // Reference model state.
    int          mk[K][K];
    int          mkcnt = 0;
    int          mfcnt = 0;
    logic [CW-1:0] mwin[$];
    logic [OW:0] exp0[$];
    logic [OW:0] exp1[$];

    function automatic int elem(input logic [CW-1:0] c, input int r);
        logic [CW-1:0] t;
        t = c >> (r * DW);
        return int'($signed(t[DW-1:0]));
    endfunction

    function automatic logic [OW:0] ref_out(input longint acc, input int sh);
        longint s, lo, hi, code;
        logic   sat;
        s   = acc >>> sh;
        lo  = -(longint'(1) << (OW - 1));
        hi  = -lo - 1;
        sat = (s < lo) || (s > hi);
        if (s < lo) s = lo;
        if (s > hi) s = hi;
        code = s - lo;
        return {code[OW-1:0], sat};
    endfunction

    function automatic void model_beat(input logic mode, input logic sof, input logic [CW-1:0] c);
        longint acc;
        if (!mode) begin
            if (mkcnt == K) begin
                mkcnt = 0;
                mfcnt = 0;
            end
            for (int r = 0; r < K; r++) mk[mkcnt][r] = elem(c, r);
            mkcnt++;
        end else if (mkcnt == K) begin
            mwin.push_back(c);
            if (mwin.size() > K) void'(mwin.pop_front());
            mfcnt = sof ? 1 : ((mfcnt < K) ? mfcnt + 1 : K);
            if (mfcnt == K) begin
                acc = 0;
                for (int ci = 0; ci < K; ci++)
                    for (int r = 0; r < K; r++)
                        acc += longint'(mk[ci][r]) * longint'(elem(mwin[ci], r));
                exp0.push_back(ref_out(acc, 7));
                exp1.push_back(ref_out(acc, 0));
            end
        end
    endfunction

    task automatic do_reset();
        rst = 1'b1;
        in_valid = 1'b0;
        in_ready = 1'b1;
        rnd_rdy = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        mkcnt = 0;
        mfcnt = 0;
        mwin.delete();
        exp0.delete();
        exp1.delete();
        obs0.delete();
        obs1.delete();
        obs_cyc.delete();
    endtask

    // Presents one beat and holds it until accepted; returns just after the accepting edge.
    task automatic beat(input logic mode, input logic sof, input logic [CW-1:0] c);
        int   n;
        logic acc;
        n = 0;
        acc = 1'b0;
        in_valid = 1'b1;
        in_mode = mode;
        in_sof = sof;
        in_col = c;
        while (!acc && n < 100) begin
            if (rnd_rdy) in_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
            acc = bus0.o_ready;
            @(posedge clk);
            #1;
            n++;
        end
        in_valid = 1'b0;
        if (acc) model_beat(mode, sof, c);
        else begin
            checks++;
            errors++;
            $display("FAIL beat_accept: o_ready stayed %b, required 1 within 100 cycles", acc);
        end
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) begin
            if (rnd_rdy) in_ready = 1'($urandom_range(0, 1));
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        rnd_rdy = 1'b0;
        in_ready = 1'b1;
        while (obs0.size() < exp0.size() && n < 50) begin
            idle(1);
            n++;
        end
        idle(4);
    endtask

    task automatic load_kernel(input logic [CW-1:0] a, input logic [CW-1:0] b,
                               input logic [CW-1:0] c);
        beat(1'b0, 1'b0, a);
        beat(1'b0, 1'b0, b);
        beat(1'b0, 1'b0, c);
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (bus0.o_valid !== 1'b0 || bus0.o_data !== '0 || bus0.o_sat !== 1'b0) begin
            errors++;
            $display("FAIL reset_out: valid=%b data=%h sat=%b, required 0/000/0",
                     bus0.o_valid, bus0.o_data, bus0.o_sat);
        end
        checks++;
        if (bus0.o_kdone !== 1'b0 || bus1.o_kdone !== 1'b0) begin
            errors++;
            $display("FAIL reset_kdone: got %b/%b, required 0/0", bus0.o_kdone, bus1.o_kdone);
        end
        checks++;
        if (bus0.o_ready !== 1'b1 || bus1.o_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_ready: got %b/%b, required 1/1", bus0.o_ready, bus1.o_ready);
        end
    endtask

    task automatic test_basic();
        do_reset();
        load_kernel(24'h7F7F7F, 24'h7F7F7F, 24'h7F7F7F);
        checks++;
        if (bus0.o_kdone !== (mkcnt == K)) begin
            errors++;
            $display("FAIL basic_kdone: got %b, required %b", bus0.o_kdone, mkcnt == K);
        end
        repeat (3) beat(1'b1, 1'b0, 24'h7F7F7F);
        checks++;
        if (bus0.o_valid !== 1'b0) begin
            errors++;
            $display("FAIL basic_lat_early: o_valid=%b one edge after accept, required 0",
                     bus0.o_valid);
        end
        @(posedge clk);
        #1;
        checks++;
        if (bus0.o_valid !== 1'b1 || bus0.o_data !== 13'h146E || bus0.o_sat !== 1'b0) begin
            errors++;
            $display("FAIL basic_s7: valid=%b data=%h sat=%b, required 1/146e/0",
                     bus0.o_valid, bus0.o_data, bus0.o_sat);
        end
        checks++;
        if (bus1.o_data !== 13'h1FFF || bus1.o_sat !== 1'b1) begin
            errors++;
            $display("FAIL basic_s0: data=%h sat=%b, required 1fff/1", bus1.o_data, bus1.o_sat);
        end
        idle(4);
        checks++;
        if (obs0.size() != 1 || exp0.size() != 1) begin
            errors++;
            $display("FAIL basic_count: got %0d samples, required 1 (model %0d)",
                     obs0.size(), exp0.size());
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        load_kernel(24'h808080, 24'h808080, 24'h808080);
        repeat (6) beat(1'b1, 1'b0, 24'h7F7F7F);
        drain();
        checks++;
        if (obs0.size() != 4 || obs1.size() != exp1.size()) begin
            errors++;
            $display("FAIL b2b_count: got %0d/%0d, required 4/%0d",
                     obs0.size(), obs1.size(), exp1.size());
        end
        for (int i = 0; i < obs0.size() && i < exp0.size(); i++) begin
            checks++;
            if (obs0[i] !== exp0[i] || obs0[i] !== {13'h0B89, 1'b0}) begin
                errors++;
                $display("FAIL b2b_s7[%0d]: got %h, required %h", i, obs0[i], exp0[i]);
            end
        end
        for (int i = 0; i < obs1.size() && i < exp1.size(); i++) begin
            checks++;
            if (obs1[i] !== exp1[i] || obs1[i] !== {13'h0000, 1'b1}) begin
                errors++;
                $display("FAIL b2b_s0[%0d]: got %h, required %h", i, obs1[i], exp1[i]);
            end
        end
        if (obs_cyc.size() == 4) begin
            checks++;
            if (obs_cyc[3] - obs_cyc[0] != 3) begin
                errors++;
                $display("FAIL b2b_spacing: 4 samples over %0d cycles, required 3",
                         obs_cyc[3] - obs_cyc[0]);
            end
        end
    endtask

    task automatic test_sof();
        do_reset();
        beat(1'b1, 1'b0, CW'($urandom));
        beat(1'b1, 1'b0, CW'($urandom));
        beat(1'b0, 1'b0, CW'($urandom));
        beat(1'b0, 1'b0, CW'($urandom));
        beat(1'b1, 1'b0, CW'($urandom));
        checks++;
        if (bus0.o_kdone !== 1'b0) begin
            errors++;
            $display("FAIL sof_kdone_partial: got %b, required 0", bus0.o_kdone);
        end
        beat(1'b0, 1'b0, CW'($urandom));
        for (int i = 0; i < 8; i++) beat(1'b1, (i == 4), CW'($urandom));
        drain();
        checks++;
        if (obs0.size() != 4 || exp0.size() != 4 || obs1.size() != 4) begin
            errors++;
            $display("FAIL sof_count: got %0d/%0d, required 4 (model %0d)",
                     obs0.size(), obs1.size(), exp0.size());
        end
        for (int i = 0; i < obs0.size() && i < exp0.size(); i++) begin
            checks++;
            if (obs0[i] !== exp0[i] || obs1[i] !== exp1[i]) begin
                errors++;
                $display("FAIL sof_data[%0d]: got %h/%h, required %h/%h",
                         i, obs0[i], obs1[i], exp0[i], exp1[i]);
            end
        end
    endtask

    task automatic test_stall();
        logic [OW:0] head;
        do_reset();
        load_kernel(CW'($urandom), CW'($urandom), CW'($urandom));
        beat(1'b1, 1'b0, CW'($urandom));
        beat(1'b1, 1'b0, CW'($urandom));
        in_ready = 1'b0;
        beat(1'b1, 1'b0, CW'($urandom));
        beat(1'b1, 1'b0, CW'($urandom));
        head = (exp0.size() > 0) ? exp0[0] : '0;
        in_valid = 1'b1;
        in_mode = 1'b1;
        in_sof = 1'b0;
        in_col = CW'($urandom);
        repeat (5) begin
            @(negedge clk);
            checks++;
            if (bus0.o_ready !== 1'b0 || bus0.o_valid !== 1'b1 ||
                {bus0.o_data, bus0.o_sat} !== head) begin
                errors++;
                $display("FAIL stall_hold: ready=%b valid=%b out=%h, required 0/1/%h",
                         bus0.o_ready, bus0.o_valid, {bus0.o_data, bus0.o_sat}, head);
            end
        end
        @(posedge clk);
        #1;
        in_ready = 1'b1;
        beat(1'b1, 1'b0, in_col);
        drain();
        checks++;
        if (obs0.size() != 3 || exp0.size() != 3 || obs1.size() != 3) begin
            errors++;
            $display("FAIL stall_count: got %0d/%0d, required 3 (model %0d)",
                     obs0.size(), obs1.size(), exp0.size());
        end
        for (int i = 0; i < obs0.size() && i < exp0.size(); i++) begin
            checks++;
            if (obs0[i] !== exp0[i] || obs1[i] !== exp1[i]) begin
                errors++;
                $display("FAIL stall_data[%0d]: got %h/%h, required %h/%h",
                         i, obs0[i], obs1[i], exp0[i], exp1[i]);
            end
        end
    endtask

    task automatic test_random();
        int sel;
        do_reset();
        load_kernel(CW'($urandom), CW'($urandom), CW'($urandom));
        rnd_rdy = 1'b1;
        for (int i = 0; i < 120; i++) begin
            sel = $urandom_range(0, 31);
            if (sel == 0) begin
                load_kernel(CW'($urandom), CW'($urandom), CW'($urandom));
            end else if (sel == 1) begin
                beat(1'b0, 1'b0, CW'($urandom));
                beat(1'b1, 1'b0, CW'($urandom));
                beat(1'b0, 1'b0, CW'($urandom));
                beat(1'b0, 1'b0, CW'($urandom));
            end else if (sel == 2) begin
                beat(1'b0, 1'b0, {K{8'h80}});
                beat(1'b0, 1'b0, {K{8'h80}});
                beat(1'b0, 1'b0, {K{8'h80}});
            end else begin
                beat(1'b1, ($urandom_range(0, 7) == 0), CW'($urandom));
                if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
            end
        end
        drain();
        checks++;
        if (obs0.size() != exp0.size() || obs1.size() != exp1.size()) begin
            errors++;
            $display("FAIL rand_count: got %0d/%0d, required %0d/%0d",
                     obs0.size(), obs1.size(), exp0.size(), exp1.size());
        end
        for (int i = 0; i < obs0.size() && i < exp0.size(); i++) begin
            checks++;
            if (obs0[i] !== exp0[i] || obs1[i] !== exp1[i]) begin
                errors++;
                $display("FAIL rand_data[%0d]: got %h/%h, required %h/%h",
                         i, obs0[i], obs1[i], exp0[i], exp1[i]);
            end
        end
    endtask

    task automatic test_reload_reset();
        do_reset();
        load_kernel(CW'($urandom), CW'($urandom), CW'($urandom));
        repeat (3) beat(1'b1, 1'b0, CW'($urandom));
        // Reload right behind the issuing beat: that token must use the old kernel.
        load_kernel(CW'($urandom), CW'($urandom), CW'($urandom));
        repeat (3) beat(1'b1, 1'b0, CW'($urandom));
        drain();
        checks++;
        if (obs0.size() != 2 || exp0.size() != 2 || obs1.size() != 2) begin
            errors++;
            $display("FAIL reload_count: got %0d/%0d, required 2 (model %0d)",
                     obs0.size(), obs1.size(), exp0.size());
        end
        for (int i = 0; i < obs0.size() && i < exp0.size(); i++) begin
            checks++;
            if (obs0[i] !== exp0[i] || obs1[i] !== exp1[i]) begin
                errors++;
                $display("FAIL reload_data[%0d]: got %h/%h, required %h/%h",
                         i, obs0[i], obs1[i], exp0[i], exp1[i]);
            end
        end
        obs0.delete();
        obs1.delete();
        // Two tokens in flight, then reset: neither may appear.
        beat(1'b1, 1'b0, CW'($urandom));
        beat(1'b1, 1'b0, CW'($urandom));
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        idle(5);
        checks++;
        if (obs0.size() != 0 || obs1.size() != 0) begin
            errors++;
            $display("FAIL rst_flush: got %0d/%0d samples after reset, required 0",
                     obs0.size(), obs1.size());
        end
        checks++;
        if (bus0.o_valid !== 1'b0 || bus0.o_kdone !== 1'b0 || bus0.o_data !== '0 ||
            bus0.o_sat !== 1'b0 || bus1.o_data !== '0) begin
            errors++;
            $display("FAIL rst_outputs: valid=%b kdone=%b data=%h sat=%b, required 0/0/000/0",
                     bus0.o_valid, bus0.o_kdone, bus0.o_data, bus0.o_sat);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_sof();
        test_stall();
        test_random();
        test_reload_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
